// File: rtl/pipe_credit_pkg.sv
// Shared definitions for the credit-gated egress buffer.
// Contents:
//   DEFAULT_DEPTH - default FIFO depth used by the buffer and its FIFO
//   credit_cnt_t  - wide counter type for credit arithmetic (DEPTH <= 256,
//                   with headroom so inflight + fifo_count cannot overflow)
//   clog2_depth() - width of a counter that must hold the values 0..DEPTH
package pipe_credit_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef logic [9:0] credit_cnt_t;

  function automatic int clog2_depth(input int depth);
    int w;
    w = $clog2(depth + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/pipe_credit_fifo.sv
// Circular DEPTH x DATA_WIDTH FIFO used as the egress store.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   i_push, i_data    - write request and data
//   i_pop             - read request (ignored when empty)
//   o_data            - head entry (don't-care when empty)
//   o_count           - number of valid entries
//   o_full, o_empty   - status flags
// A push while full is dropped unless a pop in the same cycle frees a slot.
// The storage array is deliberately not reset.
module pipe_credit_fifo
  import pipe_credit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CW         = clog2_depth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PW'(DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PW'(1);
    end
    return nxt;
  endfunction

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A simultaneous pop frees the head slot, so a push at full still lands.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage write; no reset on the data array.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_credit_egress_buffer.sv
// Credit-gated egress buffer placed after a fixed-latency, non-stalling
// pipeline. Upstream transactions are only admitted while a FIFO slot is
// reserved for their result, so results are never dropped; results are then
// re-exported on a ready/valid interface.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   up_valid / up_ready     - producer handshake (up_ready is the credit)
//   pipe_in_valid           - pipeline in_valid (= up_valid & up_ready)
//   pipe_out/pipe_out_valid - pipeline result capture
//   dn_data/dn_valid/dn_ready - consumer handshake
//   occupancy               - fifo_count + inflight
//   err                     - sticky protocol error (overflow or stray result)
module pipe_credit_egress_buffer
  import pipe_credit_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_LATENCY = 2,
  parameter int DEPTH        = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         up_valid,
  output logic                         up_ready,
  output logic                         pipe_in_valid,
  input  logic [DATA_WIDTH-1:0]        pipe_out,
  input  logic                         pipe_out_valid,
  output logic [DATA_WIDTH-1:0]        dn_data,
  output logic                         dn_valid,
  input  logic                         dn_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         err
);

  localparam int CW = clog2_depth(DEPTH);

  if (DEPTH < 1) begin : g_depth_min
    $error("pipe_credit_egress_buffer: DEPTH must be >= 1");
  end
  if (DEPTH < PIPE_LATENCY + 1) begin : g_depth_lat
    $error("pipe_credit_egress_buffer: DEPTH must be >= PIPE_LATENCY + 1");
  end

  logic [CW-1:0] r_inflight;
  logic [CW-1:0] w_inflight_nxt;
  logic          r_err;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  credit_cnt_t   w_credit_sum;
  logic          w_accept;
  logic          w_pop;
  logic          w_err_set;

  // Credit is computed from registered state only, so a pop frees its
  // credit on the following cycle and there is no path from dn_ready.
  assign w_credit_sum  = credit_cnt_t'(r_inflight) + credit_cnt_t'(w_fifo_count);
  assign up_ready      = rst_n & (w_credit_sum < credit_cnt_t'(DEPTH));
  assign w_accept      = up_valid & up_ready;
  assign pipe_in_valid = w_accept;
  assign dn_valid      = ~w_fifo_empty;
  assign w_pop         = dn_valid & dn_ready;
  assign occupancy     = CW'(w_credit_sum);
  assign err           = r_err;

  // A result with no reservation, or one arriving at a full FIFO that is not
  // draining, indicates the pipeline broke its latency contract.
  assign w_err_set = pipe_out_valid & ((w_fifo_full & ~w_pop) | (r_inflight == '0));

  // Next inflight count; a stray result saturates at zero.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_accept & ~pipe_out_valid) begin
      w_inflight_nxt = r_inflight + CW'(1);
    end else if (~w_accept & pipe_out_valid & (r_inflight != '0)) begin
      w_inflight_nxt = r_inflight - CW'(1);
    end else begin
      w_inflight_nxt = r_inflight;
    end
  end

  // Inflight counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_err      <= r_err | w_err_set;
    end
  end

  pipe_credit_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .CW         (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (pipe_out_valid),
    .i_data  (pipe_out),
    .i_pop   (w_pop),
    .o_data  (dn_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule
